// File: rtl/player_core.sv
// Player core: executes move/heal/damage instructions, tracks arena position,
// HP, invulnerability frames and death status for the renderer.
module player_core #(
    parameter int unsigned MOVE_DIV = 250000,
    parameter int unsigned STEP     = 1,
    parameter int unsigned X_MIN    = 220,
    parameter int unsigned X_MAX    = 420,
    parameter int unsigned Y_MIN    = 240,
    parameter int unsigned Y_MAX    = 400,
    parameter int unsigned START_X  = 320,
    parameter int unsigned START_Y  = 320,
    parameter int unsigned MAX_HP   = 100,
    parameter int unsigned IFRAMES  = 50000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] playerInstruction,
    input  logic        isMove,
    input  logic        startDmg,
    output logic [9:0]  posX,
    output logic [9:0]  posY,
    output logic [7:0]  playerHP,
    output logic        isDeath,
    output logic        invuln,
    output logic        dmgAck
);

    localparam logic [3:0]  OpHpy    = 4'd1;
    localparam logic [3:0]  OpDpy    = 4'd2;
    localparam logic [3:0]  OpMov    = 4'd5;
    localparam logic [10:0] XMin     = 11'(X_MIN);
    localparam logic [10:0] XMax     = 11'(X_MAX);
    localparam logic [10:0] YMin     = 11'(Y_MIN);
    localparam logic [10:0] YMax     = 11'(Y_MAX);
    localparam logic [10:0] StepW    = 11'(STEP);
    localparam logic [9:0]  StartX   = 10'(START_X);
    localparam logic [9:0]  StartY   = 10'(START_Y);
    localparam logic [7:0]  MaxHp    = 8'(MAX_HP);
    localparam logic [8:0]  MaxHp9   = 9'(MAX_HP);
    localparam logic [31:0] MoveLast = 32'(MOVE_DIV - 1);
    localparam logic [31:0] IfrLoad  = 32'(IFRAMES);

    typedef enum logic [1:0] {StIdle, StApply, StDone, StWaitLow} state_e;

    state_e      state_q;
    logic [3:0]  op_q;
    logic [7:0]  arg_q;
    logic        ack_q;
    logic [7:0]  hp_q;
    logic [31:0] ifr_q;
    logic        death_q;

    logic [31:0] mv_cnt_q, mv_cnt_d;
    logic [9:0]  x_q, x_d, y_q, y_d;

    logic        move_en;
    logic [10:0] x_ext, y_ext, x_step, y_step;
    logic [8:0]  hp_sum;
    logic [7:0]  hp_heal, hp_hit;
    logic        unused_bits;

    assign move_en = isMove && (playerInstruction[15:12] == OpMov) && !death_q;

    // Candidate position one step ahead, clamped in 11 bits so nothing wraps.
    always_comb begin
        x_ext  = {1'b0, x_q};
        y_ext  = {1'b0, y_q};
        x_step = x_ext;
        y_step = y_ext;
        case (playerInstruction[5:4])
            2'd0: y_step = (y_ext < YMin + StepW) ? YMin : y_ext - StepW;
            2'd1: x_step = (x_ext < XMin + StepW) ? XMin : x_ext - StepW;
            2'd2: y_step = (y_ext + StepW > YMax) ? YMax : y_ext + StepW;
            2'd3: x_step = (x_ext + StepW > XMax) ? XMax : x_ext + StepW;
        endcase
    end

    // Movement prescaler: cleared whenever movement is not qualified.
    always_comb begin
        mv_cnt_d = 32'd0;
        x_d      = x_q;
        y_d      = y_q;
        if (move_en) begin
            if (mv_cnt_q == MoveLast) begin
                x_d = x_step[9:0];
                y_d = y_step[9:0];
            end else begin
                mv_cnt_d = mv_cnt_q + 32'd1;
            end
        end
    end

    // Movement state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            mv_cnt_q <= 32'd0;
            x_q      <= StartX;
            y_q      <= StartY;
        end else begin
            mv_cnt_q <= mv_cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
        end
    end

    // Heal saturates at MAX_HP in 9 bits; damage floors at zero.
    always_comb begin
        hp_sum  = {1'b0, hp_q} + {1'b0, arg_q};
        hp_heal = (hp_sum > MaxHp9) ? MaxHp : hp_sum[7:0];
        hp_hit  = (arg_q >= hp_q) ? 8'd0 : hp_q - arg_q;
    end

    // Request FSM with HP, i-frame counter, death flag and ack pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            op_q    <= 4'd0;
            arg_q   <= 8'd0;
            ack_q   <= 1'b0;
            hp_q    <= MaxHp;
            ifr_q   <= 32'd0;
            death_q <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            if (ifr_q != 32'd0) ifr_q <= ifr_q - 32'd1;
            // HP only reaches zero through damage; death follows a cycle later.
            if (hp_q == 8'd0) death_q <= 1'b1;
            case (state_q)
                StIdle: begin
                    if (startDmg) begin
                        op_q    <= playerInstruction[15:12];
                        arg_q   <= playerInstruction[11:4];
                        state_q <= StApply;
                    end
                end
                StApply: begin
                    if (!death_q) begin
                        if (op_q == OpHpy) begin
                            hp_q <= hp_heal;
                        end else if (op_q == OpDpy && ifr_q == 32'd0) begin
                            hp_q  <= hp_hit;
                            ifr_q <= IfrLoad;
                        end
                    end
                    ack_q   <= 1'b1;
                    state_q <= StDone;
                end
                StDone: state_q <= StWaitLow;
                StWaitLow: begin
                    if (!startDmg) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign unused_bits = ^{playerInstruction[3:0], x_step[10], y_step[10]};

    assign posX     = x_q;
    assign posY     = y_q;
    assign playerHP = hp_q;
    assign isDeath  = death_q;
    assign invuln   = (ifr_q != 32'd0);
    assign dmgAck   = ack_q;

endmodule

// File: tb/tb_player_core.sv
// Directed bench for player_core with short prescaler and i-frame settings.
module tb_player_core;

    localparam logic [3:0] OpHpy = 4'd1;
    localparam logic [3:0] OpDpy = 4'd2;
    localparam logic [3:0] OpMov = 4'd5;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic        isMove;
    logic        startDmg;
    logic [9:0]  posX, posY;
    logic [7:0]  playerHP;
    logic        isDeath, invuln, dmgAck;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

    player_core #(
        .MOVE_DIV(4),
        .STEP    (1),
        .IFRAMES (8)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .playerInstruction(instr),
        .isMove           (isMove),
        .startDmg         (startDmg),
        .posX             (posX),
        .posY             (posY),
        .playerHP         (playerHP),
        .isDeath          (isDeath),
        .invuln           (invuln),
        .dmgAck           (dmgAck)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic move(input logic [1:0] dir, input int cycles);
        instr  = {OpMov, 6'd0, dir, 4'd0};
        isMove = 1'b1;
        ticks(cycles);
        isMove = 1'b0;
    endtask

    // Issue one request, hold startDmg for `hold` cycles, score HP at the ack.
    task automatic request(input string tag, input logic [3:0] op, input logic [7:0] arg,
                           input int hold, input logic [7:0] exp_hp,
                           output int inv_cycles, output logic death_at_ack);
        int acks = 0;
        int ack_k = -1;
        logic [31:0] e;
        exp_q.push_back({24'd0, exp_hp});
        instr        = {op, arg, 4'd0};
        startDmg     = 1'b1;
        inv_cycles   = 0;
        death_at_ack = 1'b0;
        for (int k = 1; k <= hold + 3; k++) begin
            tick();
            // A large heal on the bus during APPLY must not be picked up.
            if (k == 1) instr = {OpHpy, 8'hFF, 4'd0};
            if (k == hold) startDmg = 1'b0;
            if (invuln) inv_cycles++;
            if (dmgAck) begin
                acks++;
                ack_k        = k;
                death_at_ack = isDeath;
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk({tag, "_hp"}, {24'd0, playerHP}, e);
                end
            end
        end
        chk({tag, "_acks"}, acks, 1);
        chk({tag, "_ack_cycle"}, ack_k, 2);
        if (exp_q.size() != 0) exp_q.delete();
    endtask

    int   inv;
    logic dth;
    int   acks_seen;

    initial begin
        reset    = 1'b1;
        instr    = 16'd0;
        isMove   = 1'b0;
        startDmg = 1'b0;
        ticks(2);
        reset = 1'b0;
        tick();

        // Reset state
        chk("rst_posX", posX, 320);
        chk("rst_posY", posY, 320);
        chk("rst_hp", playerHP, 100);
        chk("rst_death", isDeath, 0);
        chk("rst_invuln", invuln, 0);
        chk("rst_ack", dmgAck, 0);

        // 1. Move right 12 cycles -> 3 steps
        move(2'd3, 12);
        chk("mv1_posX", posX, 323);
        chk("mv1_posY", posY, 320);
        // Partial count must be discarded when isMove drops
        move(2'd3, 2);
        tick();
        move(2'd3, 3);
        chk("mv_clear_posX", posX, 323);
        move(2'd3, 1);
        chk("mv_after_clear_posX", posX, 324);

        // 2. Boundaries
        move(2'd3, 95 * 4);
        chk("mv_419", posX, 419);
        move(2'd3, 20 * 4);
        chk("mv_xmax", posX, 420);
        move(2'd1, 200 * 4);
        chk("mv_xmin", posX, 220);
        move(2'd1, 5 * 4);
        chk("mv_xmin_hold", posX, 220);
        move(2'd2, 80 * 4);
        chk("mv_ymax", posY, 400);
        move(2'd0, 200 * 4);
        chk("mv_ymin", posY, 240);
        // Non-MOV op with isMove held does not move
        instr  = {OpDpy, 6'd0, 2'd3, 4'd0};
        isMove = 1'b1;
        ticks(8);
        isMove = 1'b0;
        chk("mv_wrong_op", posX, 220);

        // 3. Held DPY 30 executes once, 8 i-frames
        request("dpy30", OpDpy, 8'd30, 10, 8'd70, inv, dth);
        chk("dpy30_invuln_cycles", inv, 8);
        chk("dpy30_invuln_end", invuln, 0);

        // 4. DPY 0 loads i-frames, DPY 30 then ignored, DPY 80 kills
        request("dpy0", OpDpy, 8'd0, 1, 8'd70, inv, dth);
        chk("dpy0_invuln", invuln, 1);
        request("dpy_inv", OpDpy, 8'd30, 1, 8'd70, inv, dth);
        ticks(10);
        chk("invuln_cleared", invuln, 0);
        request("dpy80", OpDpy, 8'd80, 1, 8'd0, inv, dth);
        chk("dpy80_death_at_ack", dth, 0);
        chk("dpy80_death", isDeath, 1);
        request("heal_dead", OpHpy, 8'd50, 1, 8'd0, inv, dth);
        chk("heal_dead_death", isDeath, 1);
        move(2'd3, 8);
        chk("mv_dead_posX", posX, 220);

        // 6. Reset during APPLY aborts the request
        instr    = {OpDpy, 8'd40, 4'd0};
        startDmg = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        chk("rstapply_hp", playerHP, 100);
        chk("rstapply_posX", posX, 320);
        chk("rstapply_posY", posY, 320);
        chk("rstapply_death", isDeath, 0);
        chk("rstapply_ack", dmgAck, 0);
        reset     = 1'b0;
        startDmg  = 1'b0;
        acks_seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (dmgAck) acks_seen++;
        end
        chk("rstapply_no_ack", acks_seen, 0);
        chk("rstapply_hp_after", playerHP, 100);
        request("post_rst", OpHpy, 8'd10, 1, 8'd100, inv, dth);

        // 5. Heal caps
        request("dpy5", OpDpy, 8'd5, 1, 8'd95, inv, dth);
        request("hpy10", OpHpy, 8'd10, 1, 8'd100, inv, dth);
        ticks(10);
        request("dpy99", OpDpy, 8'd99, 1, 8'd1, inv, dth);
        request("hpy255", OpHpy, 8'd255, 1, 8'd100, inv, dth);
        chk("final_death", isDeath, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
